// File: rtl/ss_result_sequencer.sv
// Signed result to sign-magnitude BCD via one-shift-per-clock double-dabble, paged onto a
// three-digit seven-segment driver. Optional feature macro: LEADING_ZERO_BLANK_EN.
module ss_result_sequencer #(
  parameter int unsigned WIDTH  = 16,
  parameter int unsigned DIGITS = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             page,
  output logic             sign,
  output logic [3:0]       BCD0,
  output logic [3:0]       BCD1,
  output logic [3:0]       BCD2,
  output logic             more,
  output logic             busy,
  output logic             done
);

  localparam int unsigned CntW = $clog2(WIDTH + 1);
  localparam int unsigned BcdW = 4 * DIGITS;

  typedef enum logic [1:0] {
    StIdle,
    StShift,
    StCommit
  } state_e;

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]  mag_q, mag_d;
  logic [BcdW-1:0]   scratch_q, scratch_d;
  logic              pend_sign_q, pend_sign_d;
  logic [BcdW-1:0]   held_q, held_d;
  logic              sign_q, sign_d;
  logic              more_q, more_d;
  logic              done_q, done_d;
  logic              page_q;

  logic [WIDTH-1:0]  in_mag;
  logic [BcdW-1:0]   adjusted;
  logic [DIGITS-1:0] blank;
  logic [3:0]        disp [DIGITS];

  // Most negative input maps to 2^(WIDTH-1), which still fits as unsigned.
  assign in_mag = in_data[WIDTH-1] ? (~in_data + {{(WIDTH-1){1'b0}}, 1'b1}) : in_data;

  always_comb begin
    adjusted = scratch_q;
    for (int i = 0; i < int'(DIGITS); i++) begin
      if (scratch_q[4*i +: 4] >= 4'd5) begin
        adjusted[4*i +: 4] = scratch_q[4*i +: 4] + 4'd3;
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    mag_d       = mag_q;
    scratch_d   = scratch_q;
    pend_sign_d = pend_sign_q;
    held_d      = held_q;
    sign_d      = sign_q;
    more_d      = more_q;
    done_d      = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          pend_sign_d = in_data[WIDTH-1];
          mag_d       = in_mag;
          scratch_d   = '0;
          cnt_d       = '0;
          state_d     = StShift;
        end
      end
      StShift: begin
        {scratch_d, mag_d} = {adjusted, mag_q} << 1;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CntW'(WIDTH - 1)) begin
          state_d = StCommit;
        end
      end
      StCommit: begin
        held_d  = scratch_q;
        sign_d  = pend_sign_q;
        more_d  = |scratch_q[BcdW-1:12];
        done_d  = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      mag_q       <= '0;
      scratch_q   <= '0;
      pend_sign_q <= 1'b0;
      held_q      <= '0;
      sign_q      <= 1'b0;
      more_q      <= 1'b0;
      done_q      <= 1'b0;
      page_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      mag_q       <= mag_d;
      scratch_q   <= scratch_d;
      pend_sign_q <= pend_sign_d;
      held_q      <= held_d;
      sign_q      <= sign_d;
      more_q      <= more_d;
      done_q      <= done_d;
      page_q      <= page;
    end
  end

`ifdef LEADING_ZERO_BLANK_EN
  logic held_valid_q;
  logic seen_nz;

  // Out of reset nothing has been committed yet, so the display shows plain zeros.
  always_ff @(posedge clk) begin
    if (rst) begin
      held_valid_q <= 1'b0;
    end else if (state_q == StCommit) begin
      held_valid_q <= 1'b1;
    end
  end

  always_comb begin
    blank   = '0;
    seen_nz = 1'b0;
    for (int i = int'(DIGITS) - 1; i > 0; i--) begin
      seen_nz  = seen_nz | (held_q[4*i +: 4] != 4'd0);
      blank[i] = held_valid_q & ~seen_nz;
    end
  end
`else
  assign blank = '0;
`endif

  always_comb begin
    for (int i = 0; i < int'(DIGITS); i++) begin
      disp[i] = blank[i] ? 4'd15 : held_q[4*i +: 4];
    end
    if (!page_q) begin
      BCD2 = disp[2];
      BCD1 = disp[1];
      BCD0 = disp[0];
    end else begin
      BCD2 = 4'd15;
      BCD1 = disp[4];
      BCD0 = disp[3];
    end
  end

  assign in_ready = (state_q == StIdle);
  assign busy     = (state_q != StIdle);
  assign done     = done_q;
  assign sign     = sign_q;
  assign more     = more_q;

endmodule

// File: doc/ss_result_sequencer.md
# ss_result_sequencer

Converts a signed two's-complement multiplier result into sign-magnitude BCD and feeds the seven-segment driver's digit inputs (`sign`, `BCD0`..`BCD2`). The conversion is a sequential double-dabble, one shift per clock, accepted through a valid/ready handshake. Magnitudes up to 32768 need five decimal digits, but the driver shows three digits plus sign. The block therefore holds all five digits and pages them onto the display under a `page` select. It sits between the multiplier's product register and the seven-segment driver.

## Interface
Parameters:
- `WIDTH`, 16: result width in bits, two's complement.
- `DIGITS`, 5: number of BCD digits held. This is the minimum decimal width of a `WIDTH`-bit magnitude.

Ports:
- `clk` input 1: system clock. One clock domain only.
- `rst` input 1: synchronous, active-high reset.
- `in_data` input WIDTH: signed result to convert.
- `in_valid` input 1: `in_data` is valid.
- `in_ready` output 1: block can accept a result; high only in IDLE.
- `page` input 1: 0 selects digits 2..0; 1 selects digits 4..3.
- `sign` output 1: 1 means the held value is negative.
- `BCD0`, `BCD1`, `BCD2` output 4 each: digit codes to the driver.
- `more` output 1: held magnitude is greater than 999, so page 1 carries significant digits.
- `busy` output 1: conversion in progress.
- `done` output 1: one-cycle pulse when new display digits are committed.

## Operation
- States: IDLE → SHIFT → COMMIT → IDLE.
- **IDLE**
  - `in_ready`=1.
  - On `in_valid`&`in_ready`: latch `sign`=`in_data[WIDTH-1]`.
  - Latch magnitude = |`in_data`| as a WIDTH-bit unsigned value; −32768 gives 32768 with no overflow.
  - Clear the BCD scratch to 0 and the shift counter to 0, then go to SHIFT.
- **SHIFT**
  - Each cycle, first add 3 to every scratch BCD nibble that is ≥5.
  - Then left-shift the {scratch, magnitude} chain by 1.
  - Increment the counter. After WIDTH shifts, go to COMMIT.
- **COMMIT**
  - Copy the scratch into the held digit registers; update the held sign.
  - Set `more` = (any of digits 4..3 nonzero).
  - Pulse `done`, then go to IDLE.
- Held digits, held sign and `more` change only in COMMIT. The display keeps showing the previous result throughout a conversion.
- Zero result: `sign`=0 and all digits 0.
- **Paging**
  - Page 0: `BCD2`/`BCD1`/`BCD0` = digits 2/1/0.
  - Page 1: `BCD1`/`BCD0` = digits 4/3, and `BCD2` = 4'd15 (blank code; the decoder drives all segments off for codes ≥12).
  - `sign` is shown on both pages.
- `in_valid` outside IDLE is ignored; the producer holds it until `in_ready`.
- `page` is registered. The outputs follow it one cycle later and may change at any time, including during SHIFT.

## Timing
- Handshake at edge E0 → SHIFT on edges E1..E16 → COMMIT at edge E17. New digits are visible and `done`=1 after E17.
- `in_ready`=1 again after E17. Accept-to-accept spacing is therefore 18 cycles minimum.
- `busy`=1 from after E0 through the COMMIT cycle.
- Reset values, including reset asserted mid-conversion (conversion discarded):
  - State = IDLE, `in_ready`=1, `busy`=0, `done`=0.
  - `sign`=0, all held digits 0, `BCD0`..`BCD2`=0, `more`=0.
  - Page register = 0.
- Reset has priority over a handshake in the same cycle.

## Configuration
- `LEADING_ZERO_BLANK_EN` defined:
  - In the displayed page, every digit more significant than the highest nonzero held digit outputs 4'd15.
  - Digit 0 is never blanked.
  - Page 1 with `more`=0 shows all three positions blank.
- `LEADING_ZERO_BLANK_EN` undefined: leading digits are output as 4'd0. Page 1 `BCD2` is still 4'd15.

## Test plan
- Reset, then accept −1234:
  - `done` pulses at cycle 17.
  - Page 0: `sign`=1, BCD2/1/0=2/3/4, `more`=1.
  - Page 1: BCD1/BCD0=0/1 (15/1 with the macro).
- Accept 16384 → page 0 = 3/8/4, page 1 = 1/6, `sign`=0.
- Accept −32768 → digits 3,2,7,6,8, `sign`=1, `more`=1.
- Accept 0:
  - `sign`=0, page 0 = 0/0/0 (15/15/0 with the macro), `more`=0.
- Second `in_valid` at cycle 5 of a conversion → ignored. Assert `rst` at cycle 10 of the next conversion → all outputs 0 and `in_ready`=1 on the following cycle.
- Toggle `page` during SHIFT → outputs switch to the other page of the previous held result one cycle later. The held result itself is unchanged until COMMIT.
